mdu_seq: RTL and testbench

// - Iterative multiply/divide sequencer for the integer ALU. Handles the multi-cycle MULT and DIV ops
//   (IA codes 3'b010 / 3'b011 from ALU control) the single-cycle ALU cannot finish.
// - Runs unsigned shift-add multiply and restoring divide, one bit per clock.
// - Holds the pipeline via stall until HI/LO are valid. Sits beside the ALU in EX; HI/LO feed the register-file write mux.

---
 rtl/mdu_seq_pkg.sv | 25 ++
 rtl/mdu_step.sv | 47 ++++
 rtl/mdu_seq.sv | 127 ++++++++++++
 tb/tb_mdu_seq.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mdu_seq_pkg
// Description : Shared constants and FSM state encoding for the iterative
//               multiply/divide sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mdu_seq_pkg;

    localparam int c_WIDTH_DEF = 32;
    localparam int c_CNT_W_DEF = 6;

    // ALU control op codes handled by the sequencer
    localparam logic [2:0] c_IA_MULT = 3'b010;
    localparam logic [2:0] c_IA_DIV  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIN  = 2'd3
    } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/mdu_step.sv
`default_nettype none
// ============================================================================
// Module      : mdu_step
// Description : One combinational iteration of the sequencer datapath:
//               shift-add multiply or restoring compare-subtract-shift divide.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH:0]   i_hi,     // MUL: acc upper (carry kept); DIV: remainder
    input  logic [WIDTH-1:0] i_lo,     // MUL: acc lower / multiplier; DIV: quotient
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH:0]   o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0] w_b_ext;
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shl;
    logic           w_ge;
    logic [WIDTH:0] w_diff;

    assign w_b_ext = {1'b0, i_b};
    // Upper half plus B only when the current multiplier bit is set
    assign w_sum   = i_lo[0] ? (i_hi + w_b_ext) : i_hi;
    // Remainder shifted left, pulling in the next dividend bit
    assign w_shl   = {i_hi[WIDTH-1:0], i_lo[WIDTH-1]};
    assign w_ge    = (w_shl >= w_b_ext);
    assign w_diff  = w_shl - w_b_ext;

    // Select the multiply or divide form of the next accumulator value
    always_comb begin
        o_hi = '0;
        o_lo = '0;
        if (i_is_div) begin
            o_hi = w_ge ? w_diff : w_shl;
            o_lo = {i_lo[WIDTH-2:0], w_ge};
        end else begin
            o_hi = {1'b0, w_sum[WIDTH:1]};
            o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mdu_seq.sv
`default_nettype none
// ============================================================================
// Module      : mdu_seq
// Description : Iterative MULT/DIV sequencer beside the EX-stage ALU. One bit
//               per clock; stalls the pipeline until HI/LO are valid.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_seq
    import mdu_seq_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEF,
    parameter int CNT_W = c_CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       IA,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             dbz
);

    mdu_state_e       r_state;
    mdu_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_hi_wrk;
    logic [WIDTH-1:0] r_lo_wrk;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH:0]   w_hi_step;
    logic [WIDTH-1:0] w_lo_step;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             w_valid_op;
    logic             w_accept;
    logic             w_div_zero;
    logic             w_iterating;

    assign w_valid_op  = (IA == c_IA_MULT) || (IA == c_IA_DIV);
    assign w_accept    = start && w_valid_op && (r_state == ST_IDLE);
    assign w_div_zero  = (IA == c_IA_DIV) && (B == '0);
    assign w_iterating = (r_state == ST_MUL) || (r_state == ST_DIV);

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (r_state == ST_DIV),
        .i_hi     (r_hi_wrk),
        .i_lo     (r_lo_wrk),
        .i_b      (r_b),
        .o_hi     (w_hi_step),
        .o_lo     (w_lo_step)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state: divide by zero skips the iterations and goes straight to FIN
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (IA == c_IA_MULT) w_state_nxt = ST_MUL;
                    else if (w_div_zero) w_state_nxt = ST_FIN;
                    else                 w_state_nxt = ST_DIV;
                end
            end
            ST_MUL, ST_DIV: if (r_cnt == '0) w_state_nxt = ST_FIN;
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, per-bit iteration, and result publish on leaving FIN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_hi_wrk <= '0;
            r_lo_wrk <= '0;
            r_b      <= '0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_cnt <= CNT_W'(WIDTH - 1);
                r_b   <= B;
                r_dbz <= w_div_zero;
                // Divide by zero preloads the defined result: HI=A, LO=all ones
                if (w_div_zero) begin
                    r_hi_wrk <= {1'b0, A};
                    r_lo_wrk <= '1;
                end else begin
                    r_hi_wrk <= '0;
                    r_lo_wrk <= A;
                end
            end else if (w_iterating) begin
                r_hi_wrk <= w_hi_step;
                r_lo_wrk <= w_lo_step;
                if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            end else if (r_state == ST_FIN) begin
                r_hi   <= r_hi_wrk[WIDTH-1:0];
                r_lo   <= r_lo_wrk;
                r_done <= 1'b1;
            end
        end
    end

    assign busy  = (r_state != ST_IDLE);
    assign stall = busy || w_accept;
    assign done  = r_done;
    assign HI    = r_hi;
    assign LO    = r_lo;
    assign dbz   = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_mdu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_seq
// Description : Self-checking bench for mdu_seq against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_seq;
    import mdu_seq_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   IA;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         busy;
    logic         stall;
    logic         done;
    logic [W-1:0] HI;
    logic [W-1:0] LO;
    logic         dbz;

    int n_cmp = 0;
    int n_bad = 0;

    mdu_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .IA    (IA),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .stall (stall),
        .done  (done),
        .HI    (HI),
        .LO    (LO),
        .dbz   (dbz)
    );

    always #5 clk = ~clk;

    // Arithmetic reference: full product, or quotient/remainder with the zero-divisor rule
    function automatic void ref_op(input logic [2:0] ia, input logic [W-1:0] a, input logic [W-1:0] b,
                                   output logic [W-1:0] hi, output logic [W-1:0] lo, output logic z);
        logic [2*W-1:0] p;
        if (ia == c_IA_MULT) begin
            p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            hi = p[2*W-1:W];
            lo = p[W-1:0];
            z  = 1'b0;
        end else if (b == '0) begin
            hi = a;
            lo = '1;
            z  = 1'b1;
        end else begin
            hi = a % b;
            lo = a / b;
            z  = 1'b0;
        end
    endfunction

    // Issue one op for a single cycle; returns edges from accept to done and busy cycle count
    task automatic do_op(input logic [2:0] ia, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cyc, output logic stall_pre, output logic dbz_acc);
        @(negedge clk);
        start = 1'b1; IA = ia; A = a; B = b;
        #1 stall_pre = stall;
        @(posedge clk); #1;
        dbz_acc = dbz;
        start = 1'b0; IA = 3'($urandom); A = $urandom; B = $urandom;
        lat = 0; busy_cyc = 0;
        while (!done && lat < 200) begin
            if (busy) busy_cyc++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; IA = 3'b000; A = '0; B = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if ({busy, stall, done, dbz} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {busy, stall, done, dbz}); end
        n_cmp++; if (HI !== '0 || LO !== '0) begin n_bad++; $display("FAIL reset_hilo got %h/%h want 0/0", HI, LO); end
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_mult(input logic [W-1:0] a, input logic [W-1:0] b, input string nm);
        int lat, bc; logic sp, da; logic [W-1:0] eh, el; logic ez;
        ref_op(c_IA_MULT, a, b, eh, el, ez);
        do_op(c_IA_MULT, a, b, lat, bc, sp, da);
        n_cmp++; if (sp !== 1'b1) begin n_bad++; $display("FAIL %s stall_at_start got %b want 1", nm, sp); end
        n_cmp++; if (lat !== W + 1) begin n_bad++; $display("FAIL %s latency got %0d want %0d", nm, lat, W + 1); end
        n_cmp++; if (bc !== W + 1) begin n_bad++; $display("FAIL %s busy_cycles got %0d want %0d", nm, bc, W + 1); end
        n_cmp++; if (HI !== eh || LO !== el || dbz !== ez) begin n_bad++; $display("FAIL %s result got %h/%h/%b want %h/%h/%b", nm, HI, LO, dbz, eh, el, ez); end
        @(posedge clk); #1;
        n_cmp++; if (done !== 1'b0 || HI !== eh || LO !== el) begin n_bad++; $display("FAIL %s pulse_hold got done=%b %h/%h want 0 %h/%h", nm, done, HI, LO, eh, el); end
    endtask

    task automatic test_div(input logic [W-1:0] a, input logic [W-1:0] b, input string nm);
        int lat, bc; logic sp, da; logic [W-1:0] eh, el; logic ez;
        ref_op(c_IA_DIV, a, b, eh, el, ez);
        do_op(c_IA_DIV, a, b, lat, bc, sp, da);
        n_cmp++; if (lat !== W + 1) begin n_bad++; $display("FAIL %s latency got %0d want %0d", nm, lat, W + 1); end
        n_cmp++; if (HI !== eh || LO !== el || dbz !== ez) begin n_bad++; $display("FAIL %s result got %h/%h/%b want %h/%h/%b", nm, HI, LO, dbz, eh, el, ez); end
    endtask

    task automatic test_dbz();
        int lat, bc; logic sp, da;
        do_op(c_IA_DIV, 32'd5, 32'd0, lat, bc, sp, da);
        n_cmp++; if (lat !== 1 || bc !== 1) begin n_bad++; $display("FAIL dbz_latency got %0d/%0d want 1/1", lat, bc); end
        n_cmp++; if (HI !== 32'd5 || LO !== 32'hFFFFFFFF || dbz !== 1'b1) begin n_bad++; $display("FAIL dbz_result got %h/%h/%b want 5/ffffffff/1", HI, LO, dbz); end
        do_op(c_IA_MULT, 32'd3, 32'd3, lat, bc, sp, da);
        n_cmp++; if (da !== 1'b0) begin n_bad++; $display("FAIL dbz_clear_at_accept got %b want 0", da); end
        n_cmp++; if (LO !== 32'd9 || HI !== 32'd0 || dbz !== 1'b0) begin n_bad++; $display("FAIL after_dbz_mult got %h/%h/%b want 0/9/0", HI, LO, dbz); end
    endtask

    task automatic test_ignore();
        logic [W-1:0] hh, ll;
        logic [2:0] codes [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        hh = HI; ll = LO;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = 1'b1; IA = codes[i]; A = $urandom; B = $urandom;
            #1;
            n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL ignore_stall ia=%b got %b want 0", codes[i], stall); end
            repeat (2) @(posedge clk);
            #1;
            n_cmp++; if ({busy, stall, done} !== 3'b000 || HI !== hh || LO !== ll) begin n_bad++; $display("FAIL ignore ia=%b got %b %h/%h want 000 %h/%h", codes[i], {busy, stall, done}, HI, LO, hh, ll); end
        end
        @(negedge clk) start = 1'b0;
    endtask

    task automatic test_back_to_back();
        int t, d1, d2; logic [W-1:0] h1, l1, h2, l2, eh, el; logic ez;
        @(negedge clk);
        start = 1'b1; IA = c_IA_DIV; A = 32'd1000; B = 32'd33;
        @(posedge clk); #1;
        A = 32'hDEADBEEF; B = 32'd12345;
        t = 0; d1 = -1; d2 = -1;
        while (d2 < 0 && t < 300) begin
            if (done) begin
                if (d1 < 0) begin d1 = t; h1 = HI; l1 = LO; end
                else        begin d2 = t; h2 = HI; l2 = LO; end
            end
            @(posedge clk); #1;
            t++;
        end
        start = 1'b0;
        n_cmp++; if (d1 !== W + 1) begin n_bad++; $display("FAIL b2b_first_done got %0d want %0d", d1, W + 1); end
        n_cmp++; if (d2 - d1 !== W + 2) begin n_bad++; $display("FAIL b2b_spacing got %0d want %0d", d2 - d1, W + 2); end
        ref_op(c_IA_DIV, 32'd1000, 32'd33, eh, el, ez);
        n_cmp++; if (h1 !== eh || l1 !== el) begin n_bad++; $display("FAIL b2b_first got %h/%h want %h/%h", h1, l1, eh, el); end
        ref_op(c_IA_DIV, 32'hDEADBEEF, 32'd12345, eh, el, ez);
        n_cmp++; if (h2 !== eh || l2 !== el) begin n_bad++; $display("FAIL b2b_second got %h/%h want %h/%h", h2, l2, eh, el); end
    endtask

    task automatic test_reset_midop();
        int lat, bc; logic sp, da;
        @(negedge clk);
        start = 1'b1; IA = c_IA_MULT; A = 32'd7; B = 32'd6;
        @(posedge clk); #1 start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if ({busy, stall, done, dbz} !== 4'b0000 || HI !== '0 || LO !== '0) begin n_bad++; $display("FAIL midop_reset got %b %h/%h want 0000 0/0", {busy, stall, done, dbz}, HI, LO); end
        @(negedge clk) rst = 1'b0;
        do_op(c_IA_MULT, 32'd7, 32'd6, lat, bc, sp, da);
        n_cmp++; if (lat !== W + 1 || LO !== 32'd42 || HI !== 32'd0) begin n_bad++; $display("FAIL midop_restart got lat=%0d %h/%h want %0d 0/2a", lat, HI, LO, W + 1); end
    endtask

    task automatic test_random(input int n);
        int lat, bc; logic sp, da; logic [2:0] ia; logic [W-1:0] a, b, eh, el; logic ez; int sel;
        for (int i = 0; i < n; i++) begin
            ia  = ($urandom_range(0, 1) == 0) ? c_IA_MULT : c_IA_DIV;
            a   = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
            sel = $urandom_range(0, 7);
            b   = (sel == 0) ? '0 : (sel < 3) ? W'($urandom_range(1, 15)) : W'($urandom);
            ref_op(ia, a, b, eh, el, ez);
            do_op(ia, a, b, lat, bc, sp, da);
            n_cmp++; if (lat !== (ez ? 1 : W + 1)) begin n_bad++; $display("FAIL rand%0d latency got %0d want %0d", i, lat, ez ? 1 : W + 1); end
            n_cmp++; if (HI !== eh || LO !== el || dbz !== ez) begin n_bad++; $display("FAIL rand%0d ia=%b a=%h b=%h got %h/%h/%b want %h/%h/%b", i, ia, a, b, HI, LO, dbz, eh, el, ez); end
        end
    endtask

    initial begin
        test_reset();
        test_mult(32'd7, 32'd6, "mult_7x6");
        test_mult(32'hFFFFFFFF, 32'hFFFFFFFF, "mult_max");
        test_div(32'd100, 32'd7, "div_100_7");
        test_div(32'hFFFFFFFF, 32'd1, "div_max_1");
        test_dbz();
        test_ignore();
        test_back_to_back();
        test_reset_midop();
        test_random(24);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
